adxl_xfer_sched: RTL and testbench
==================================

// Module: adxl_xfer_sched
// PURPOSE
//  Transaction scheduler for the ADXL362 link. Sequences a byte-level SPI engine: power-up wait,
//  one POWER_CTL init write, then periodic 6-byte X/Y/Z burst reads. Shares the link with a host
//  single-register read/write port, arbitrated only between frames. Drives CS; engine shifts bits.
// PARAMETERS
//  PWRUP_TICKS   24000  iclk cycles CS held high after reset before init frame (~6 ms @ 4 MHz)
//  PERIOD_TICKS  40000  iclk cycles between sample-frame requests (~10 ms @ 4 MHz)
//  GAP_TICKS     8      min iclk cycles CS high after any frame before next frame
//  PWRCTL_VAL    8'h02  byte written to POWER_CTL (0x2D) during init (measurement mode)
// PORTS
//  iclk        in   1   single clock; all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  eng_cs_n    out  1   chip select to ADXL362, low during frame
//  eng_start   out  1   1-cycle strobe: engine shifts eng_tx out (MSB first)
//  eng_tx      out  8   byte to send; stable from eng_start until eng_done
//  eng_done    in   1   1-cycle strobe: byte complete, eng_rx valid this cycle
//  eng_rx      in   8   byte received during last transfer
//  host_req    in   1   level; held high until host_ack
//  host_wr     in   1   1=write, 0=read; sampled with host_req when frame starts
//  host_addr   in   8   register address; sampled when frame starts
//  host_wdata  in   8   write data; sampled when frame starts
//  host_ack    out  1   1-cycle pulse at end of host frame
//  host_rdata  out  8   read byte; valid with host_ack on reads, holds value otherwise
//  x_raw       out  16  {X_H,X_L} as received, no sign processing
//  y_raw       out  16  {Y_H,Y_L}
//  z_raw       out  16  {Z_H,Z_L}
//  xyz_valid   out  1   1-cycle pulse; x/y/z_raw updated same cycle
//  init_done   out  1   high once init frame and its gap complete; stays high until rst
// BEHAVIOUR
//  Reset: eng_cs_n=1, eng_start=0, eng_tx=0, host_ack=0, host_rdata=0, x/y/z_raw=0, xyz_valid=0,
//   init_done=0; all counters 0, sample-pending=0, state PWRUP. Reset mid-frame: CS high next edge,
//   no xyz_valid/host_ack for the aborted frame; engine shares rst.
//  States: PWRUP -> INIT_FRM -> GAP -> IDLE -> {SMP_FRM | HOST_FRM} -> GAP -> IDLE ...
//  PWRUP: count PWRUP_TICKS cycles, then drop CS and enter INIT_FRM.
//  Frame byte rule: CS falls one cycle before first eng_start; each byte = one eng_start then wait
//   for eng_done; next eng_start the cycle after eng_done; never start while a byte is in flight.
//   eng_done outside a wait is ignored. CS rises the cycle after the last eng_done.
//  INIT_FRM bytes: 0A 2D PWRCTL_VAL. SMP_FRM: 0B 0E 00x6 (rx bytes 3..8 = XL XH YL YH ZL ZH).
//   Host write: 0A addr wdata. Host read: 0B addr 00 (rx of byte 3 -> host_rdata).
//  GAP: CS high for GAP_TICKS cycles; after the init frame's gap, init_done=1, period counter starts.
//  Period counter: free-running after init_done; wraps at PERIOD_TICKS-1 and sets sample-pending
//   (saturates at 1; extra expiries while pending are dropped, not queued).
//  IDLE arbitration: pending -> SMP_FRM (clears pending); else host_req -> HOST_FRM; same-cycle
//   tie -> sample first, host served next IDLE. host_req ignored before init_done.
//  End of SMP_FRM (cycle CS rises): x/y/z_raw load, xyz_valid=1. End of HOST_FRM: host_ack=1.
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING (PWRUP_TICKS=20, PERIOD_TICKS=400, GAP_TICKS=8; engine BFM models byte timing)
//  1 Release rst -> eng_cs_n=1 for 20 cycles, then bytes 0A 2D 02, CS high, init_done=1 after 8-cycle gap.
//  2 Sample frame, BFM rx 11 22 33 44 55 66 -> tx 0B 0E 00x6; x=16'h2211 y=16'h4433 z=16'h6655, one xyz_valid pulse.
//  3 Host read addr 00, BFM returns AD -> tx 0B 00 00, host_ack 1 pulse, host_rdata=AD; write 1F/52 -> tx 0A 1F 52.
//  4 host_req rises same cycle pending sets -> sample frame first, gap, host frame; host_ack exactly once.
//  5 Hold frames so 2 periods expire (BFM stalls eng_done) -> only one sample frame afterwards, no back-to-back dup.
//  6 Assert rst after 3rd eng_done of sample frame -> eng_cs_n=1 next cycle, no xyz_valid, restart from PWRUP.

Source files
------------

// File: rtl/adxl_xfer_sched.sv
// Frame scheduler for the ADXL362 SPI link: power-up wait, one POWER_CTL write, then periodic
// X/Y/Z burst reads, interleaved between frames with host single-register accesses.
`timescale 1ns/1ps
module adxl_xfer_sched #(
   parameter int unsigned PWRUP_TICKS  = 24000,
   parameter int unsigned PERIOD_TICKS = 40000,
   parameter int unsigned GAP_TICKS    = 8,
   parameter logic [7:0]  PWRCTL_VAL   = 8'h02
) (
   input  logic        iclk,
   input  logic        rst,
   output logic        eng_cs_n,
   output logic        eng_start,
   output logic [7:0]  eng_tx,
   input  logic        eng_done,
   input  logic [7:0]  eng_rx,
   input  logic        host_req,
   input  logic        host_wr,
   input  logic [7:0]  host_addr,
   input  logic [7:0]  host_wdata,
   output logic        host_ack,
   output logic [7:0]  host_rdata,
   output logic [15:0] x_raw,
   output logic [15:0] y_raw,
   output logic [15:0] z_raw,
   output logic        xyz_valid,
   output logic        init_done
);

   localparam int unsigned PH_MAX = (PWRUP_TICKS > GAP_TICKS) ? PWRUP_TICKS : GAP_TICKS;
   localparam int PH_W  = $clog2(PH_MAX + 1);
   localparam int PER_W = $clog2(PERIOD_TICKS + 1);

   typedef enum logic [2:0] {
      S_PWRUP, S_INIT_FRM, S_SMP_FRM, S_HOST_FRM, S_GAP, S_IDLE
   } state_t;

   state_t           state;
   logic [PH_W-1:0]  ph_cnt;
   logic [PER_W-1:0] per_cnt;
   logic             pending;
   logic [3:0]       byte_idx;
   logic             busy;
   logic             gap_after_init;
   logic             hwr;
   logic [7:0]       haddr;
   logic [7:0]       hwdata;
   logic [39:0]      rx_sh;
   logic             is_last;
   logic             per_wrap;

   function automatic logic [7:0] frame_byte(input state_t st, input logic [3:0] idx,
                                             input logic wr, input logic [7:0] addr,
                                             input logic [7:0] wdata);
      logic [7:0] b;
      b = 8'h00;
      case (st)
         S_INIT_FRM: case (idx)
            4'd0:    b = 8'h0A;
            4'd1:    b = 8'h2D;
            default: b = PWRCTL_VAL;
         endcase
         S_SMP_FRM: case (idx)
            4'd0:    b = 8'h0B;
            4'd1:    b = 8'h0E;
            default: b = 8'h00;
         endcase
         S_HOST_FRM: case (idx)
            4'd0:    b = wr ? 8'h0A : 8'h0B;
            4'd1:    b = addr;
            default: b = wr ? wdata : 8'h00;
         endcase
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign is_last  = (state == S_SMP_FRM) ? (byte_idx == 4'd7) : (byte_idx == 4'd2);
   assign per_wrap = init_done && (per_cnt == PER_W'(PERIOD_TICKS - 1));

   always_ff @(posedge iclk) begin
      if (rst) begin
         state          <= S_PWRUP;
         eng_cs_n       <= 1'b1;
         eng_start      <= 1'b0;
         eng_tx         <= 8'h00;
         host_ack       <= 1'b0;
         host_rdata     <= 8'h00;
         x_raw          <= 16'h0000;
         y_raw          <= 16'h0000;
         z_raw          <= 16'h0000;
         xyz_valid      <= 1'b0;
         init_done      <= 1'b0;
         ph_cnt         <= '0;
         per_cnt        <= '0;
         pending        <= 1'b0;
         byte_idx       <= 4'd0;
         busy           <= 1'b0;
         gap_after_init <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         host_ack  <= 1'b0;
         xyz_valid <= 1'b0;

         if (init_done) per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;

         case (state)
            S_PWRUP: begin
               if (ph_cnt == PH_W'(PWRUP_TICKS - 1)) begin
                  ph_cnt   <= '0;
                  eng_cs_n <= 1'b0;
                  byte_idx <= 4'd0;
                  busy     <= 1'b0;
                  state    <= S_INIT_FRM;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end
            S_INIT_FRM, S_SMP_FRM, S_HOST_FRM: begin
               // busy marks a byte in flight; eng_done is only honoured while it is set
               if (!busy) begin
                  eng_start <= 1'b1;
                  eng_tx    <= frame_byte(state, byte_idx, hwr, haddr, hwdata);
                  busy      <= 1'b1;
               end else if (eng_done) begin
                  rx_sh <= {eng_rx, rx_sh[39:8]};
                  if (is_last) begin
                     eng_cs_n       <= 1'b1;
                     busy           <= 1'b0;
                     ph_cnt         <= '0;
                     gap_after_init <= (state == S_INIT_FRM);
                     state          <= S_GAP;
                     if (state == S_SMP_FRM) begin
                        x_raw     <= rx_sh[15:0];
                        y_raw     <= rx_sh[31:16];
                        z_raw     <= {eng_rx, rx_sh[39:32]};
                        xyz_valid <= 1'b1;
                     end
                     if (state == S_HOST_FRM) begin
                        host_ack <= 1'b1;
                        if (!hwr) host_rdata <= eng_rx;
                     end
                  end else begin
                     byte_idx  <= byte_idx + 4'd1;
                     eng_start <= 1'b1;
                     eng_tx    <= frame_byte(state, byte_idx + 4'd1, hwr, haddr, hwdata);
                  end
               end
            end
            S_GAP: begin
               if (ph_cnt == PH_W'(GAP_TICKS - 1)) begin
                  state <= S_IDLE;
                  if (gap_after_init) init_done <= 1'b1;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (pending) begin
                  pending  <= 1'b0;
                  eng_cs_n <= 1'b0;
                  byte_idx <= 4'd0;
                  busy     <= 1'b0;
                  state    <= S_SMP_FRM;
               end else if (host_req && init_done) begin
                  hwr      <= host_wr;
                  haddr    <= host_addr;
                  hwdata   <= host_wdata;
                  eng_cs_n <= 1'b0;
                  byte_idx <= 4'd0;
                  busy     <= 1'b0;
                  state    <= S_HOST_FRM;
               end
            end
            default: state <= S_PWRUP;
         endcase

         // an expiry landing on the same edge a pending sample is consumed counts as a new period
         if (per_wrap) pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adxl_xfer_sched.sv
// Scoreboard bench for adxl_xfer_sched with a byte-level SPI engine model.
`timescale 1ns/1ps
module tb_adxl_xfer_sched;
   localparam int PWRUP = 20, PERIOD = 400, GAP = 8;

   logic        iclk = 1'b0;
   logic        rst, eng_cs_n, eng_start, eng_done, host_req, host_wr, host_ack, xyz_valid, init_done;
   logic [7:0]  eng_tx, eng_rx, host_addr, host_wdata, host_rdata;
   logic [15:0] x_raw, y_raw, z_raw;

   always #5 iclk = ~iclk;

   adxl_xfer_sched #(.PWRUP_TICKS(PWRUP), .PERIOD_TICKS(PERIOD), .GAP_TICKS(GAP),
                     .PWRCTL_VAL(8'h02)) dut (
      .iclk(iclk), .rst(rst), .eng_cs_n(eng_cs_n), .eng_start(eng_start), .eng_tx(eng_tx),
      .eng_done(eng_done), .eng_rx(eng_rx), .host_req(host_req), .host_wr(host_wr),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
      .host_rdata(host_rdata), .x_raw(x_raw), .y_raw(y_raw), .z_raw(z_raw),
      .xyz_valid(xyz_valid), .init_done(init_done));

   int total = 0, bad = 0, cyc = 0, t0 = 0;
   int xyz_cnt = 0, ack_cnt = 0, done_cnt = 0, stall_next = 0;
   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];
   logic [47:0] xyzq[$];
   logic [8:0]  hostq[$];

   always @(posedge iclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   // Engine model: 3-cycle byte latency unless a one-shot stall is armed; shares rst.
   initial begin
      int cnt;
      cnt = 0;
      eng_done = 1'b0;
      eng_rx = 8'h00;
      forever begin
         @(posedge iclk);
         #1;
         eng_done = 1'b0;
         if (rst) cnt = 0;
         else if (eng_start) begin
            cnt = (stall_next > 0) ? stall_next : 3;
            stall_next = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               eng_done = 1'b1;
               eng_rx = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
               done_cnt++;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a byte, a sample set or a host ack.
   initial begin
      logic [8:0] h;
      forever begin
         @(negedge iclk);
         if (eng_start) begin
            if (txq.size() == 0) begin
               total++; bad++;
               $display("FAIL tx_unexpected: got %h required no byte", eng_tx);
            end else chk("tx_byte", {40'd0, eng_tx}, {40'd0, txq.pop_front()});
            chk("tx_cs_low", 48'(eng_cs_n), 48'd0);
         end
         if (xyz_valid) begin
            xyz_cnt++;
            if (xyzq.size() == 0) begin
               total++; bad++;
               $display("FAIL xyz_unexpected: got %h required no sample", {x_raw, y_raw, z_raw});
            end else chk("xyz", {x_raw, y_raw, z_raw}, xyzq.pop_front());
         end
         if (host_ack) begin
            ack_cnt++;
            if (hostq.size() == 0) begin
               total++; bad++;
               $display("FAIL ack_unexpected: got ack required none");
            end else begin
               h = hostq.pop_front();
               if (h[8]) chk("host_rdata", 48'(host_rdata), 48'(h[7:0]));
            end
         end
      end
   end

   task automatic push_smp_tx();
      txq.push_back(8'h0B);
      txq.push_back(8'h0E);
      for (int i = 0; i < 6; i++) txq.push_back(8'h00);
   endtask

   task automatic push_smp_rx(input logic [47:0] rx, input logic [47:0] exp_xyz);
      rxq.push_back(8'h00);
      rxq.push_back(8'h00);
      for (int i = 0; i < 6; i++) rxq.push_back(rx[8*i +: 8]);
      xyzq.push_back(exp_xyz);
   endtask

   task automatic host_go(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input int lim);
      int n;
      n = 0;
      host_req = 1'b1; host_wr = wr; host_addr = addr; host_wdata = wdata;
      while (!host_ack && n < lim) begin step(); n++; end
      chk("host_ack_seen", 48'(host_ack), 48'd1);
      host_req = 1'b0;
   endtask

   task automatic bringup();
      int n;
      txq.push_back(8'h0A); txq.push_back(8'h2D); txq.push_back(8'h02);
      @(negedge iclk);
      rst = 1'b0;
      n = 0;
      do begin step(); n++; end while (eng_cs_n && n < 100);
      chk("pwrup_len", 48'(n), 48'd20);
      n = 0;
      while (!eng_cs_n && n < 200) begin step(); n++; end
      chk("init_frm_end", 48'(eng_cs_n), 48'd1);
      chk("init_done_early", 48'(init_done), 48'd0);
      n = 0;
      while (!init_done && n < 50) begin step(); n++; end
      chk("init_gap", 48'(n), 48'd8);
      t0 = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, b_ack, b_xyz, b_done;
      rst = 1'b1; host_req = 1'b0; host_wr = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
      repeat (3) @(posedge iclk);
      #1;
      chk("rst_cs_n", 48'(eng_cs_n), 48'd1);
      chk("rst_start_tx", {39'd0, eng_start, eng_tx}, 48'd0);
      chk("rst_host", {39'd0, host_ack, host_rdata}, 48'd0);
      chk("rst_raw", {x_raw, y_raw, z_raw}, 48'd0);
      chk("rst_flags", {46'd0, xyz_valid, init_done}, 48'd0);

      bringup();

      // periodic sample frame
      push_smp_tx();
      push_smp_rx(48'h665544332211, 48'h2211_4433_6655);
      b_xyz = xyz_cnt; n = 0;
      while (xyz_cnt == b_xyz && n < 1000) begin step(); n++; end
      chk("smp_frame_seen", 48'(xyz_cnt - b_xyz), 48'd1);
      chk("xyz_pulse_width", 48'(xyz_valid), 48'd0);
      chk("x_raw_hold", 48'(x_raw), 48'h2211);

      // host read then write
      repeat (12) step();
      txq.push_back(8'h0B); txq.push_back(8'h00); txq.push_back(8'h00);
      rxq.push_back(8'h00); rxq.push_back(8'h00); rxq.push_back(8'hAD);
      hostq.push_back({1'b1, 8'hAD});
      host_go(1'b0, 8'h00, 8'h00, 200);
      chk("rd_rdata", 48'(host_rdata), 48'hAD);
      repeat (12) step();
      txq.push_back(8'h0A); txq.push_back(8'h1F); txq.push_back(8'h52);
      hostq.push_back({1'b0, 8'h00});
      host_go(1'b1, 8'h1F, 8'h52, 200);
      chk("wr_rdata_hold", 48'(host_rdata), 48'hAD);

      // host_req rises in the same cycle the sample-pending flag sets
      while (cyc < t0 + 2 * PERIOD) step();
      push_smp_tx();
      push_smp_rx(48'hA6A5A4A3A2A1, 48'hA2A1_A4A3_A6A5);
      txq.push_back(8'h0B); txq.push_back(8'h02); txq.push_back(8'h00);
      rxq.push_back(8'h00); rxq.push_back(8'h00); rxq.push_back(8'hF2);
      hostq.push_back({1'b1, 8'hF2});
      b_ack = ack_cnt; b_xyz = xyz_cnt;
      host_go(1'b0, 8'h02, 8'h00, 300);
      chk("tie_smp_first", 48'(xyz_cnt - b_xyz), 48'd1);
      repeat (20) step();
      chk("tie_ack_once", 48'(ack_cnt - b_ack), 48'd1);

      // stalled host frame spans two period expiries
      txq.push_back(8'h0A); txq.push_back(8'h20); txq.push_back(8'h33);
      hostq.push_back({1'b0, 8'h00});
      push_smp_tx();
      stall_next = 900;
      host_go(1'b1, 8'h20, 8'h33, 1500);
      push_smp_rx(48'hC6C5C4C3C2C1, 48'hC2C1_C4C3_C6C5);
      b_xyz = xyz_cnt;
      while (cyc < t0 + 5 * PERIOD) step();
      chk("stall_one_smp", 48'(xyz_cnt - b_xyz), 48'd1);

      // reset during a sample frame, right after its third byte completes
      txq.push_back(8'h0B); txq.push_back(8'h0E); txq.push_back(8'h00); txq.push_back(8'h00);
      b_done = done_cnt; b_xyz = xyz_cnt; n = 0;
      while (done_cnt - b_done < 3 && n < 400) begin @(negedge iclk); n++; end
      chk("abort_3rd_done", 48'(done_cnt - b_done), 48'd3);
      @(posedge iclk);
      #2 rst = 1'b1;
      @(posedge iclk);
      #2;
      chk("abort_cs_n", 48'(eng_cs_n), 48'd1);
      chk("abort_start", 48'(eng_start), 48'd0);
      repeat (3) step();
      chk("abort_no_xyz", 48'(xyz_cnt - b_xyz), 48'd0);
      chk("abort_raw_clr", {x_raw, y_raw, z_raw}, 48'd0);
      chk("abort_init_clr", 48'(init_done), 48'd0);

      bringup();
      repeat (5) step();
      chk("txq_drained", 48'(txq.size()), 48'd0);
      chk("xyzq_drained", 48'(xyzq.size()), 48'd0);
      chk("hostq_drained", 48'(hostq.size()), 48'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
